icache_direct: RTL and testbench

//   Direct-mapped, read-only instruction cache between the IF stage and the memory controller.
//   On a hit it returns a 32-bit instruction one cycle after the request.
//   On a miss it issues one 4-byte read to the memory controller, fills the line, then returns the word.
//   A jump flush aborts the outstanding fetch so the pipeline can redirect.

---
 rtl/icache_direct_if.sv | 40 ++++
 rtl/icache_direct.sv | 113 +++++++++++
 tb/tb_icache_direct.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// Bus bundle between the instruction cache, the IF stage and the memory controller.
// The cache owns the "master" view; the surrounding pipeline/memory environment owns "slave".
interface icache_direct_if;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rdy;
    logic [31:0] if_ins;
    logic [1:0]  mc_op;
    logic [1:0]  mc_len;
    logic [31:0] mc_addr;
    logic        mc_rdy;
    logic [31:0] mc_out;

    modport master (
        input  flush,
        input  if_req,
        input  if_addr,
        input  mc_rdy,
        input  mc_out,
        output if_rdy,
        output if_ins,
        output mc_op,
        output mc_len,
        output mc_addr
    );

    modport slave (
        output flush,
        output if_req,
        output if_addr,
        output mc_rdy,
        output mc_out,
        input  if_rdy,
        input  if_ins,
        input  mc_op,
        input  mc_len,
        input  mc_addr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Hits answer one cycle after the request; misses issue a single 4-byte read
// to the memory controller, fill the line and then answer. A flush drops the
// outstanding fetch. rdy_in low freezes every register, array and output.
module icache_direct #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_BITS  = 18
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    icache_direct_if.master  bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t                state;
    logic [LINES-1:0]      valid_bits;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    // Index and tag of the line being filled, latched at miss time so that
    // if_req/if_addr are free to change while the read is outstanding.
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_hit;
    logic                  fill_done;
    logic                  unused_addr_bits;

    assign req_index = bus.if_addr[INDEX_BITS+1:2];
    assign req_tag   = bus.if_addr[ADDR_BITS-1:INDEX_BITS+2];
    assign req_hit   = valid_bits[req_index] && (tag_mem[req_index] == req_tag);

    // A fill completes whenever the read returns while not frozen, even if a
    // flush arrives in the same cycle: the data is still correct for that line.
    assign fill_done = rdy_in && (state == FILL) && bus.mc_rdy;

    // Instruction addresses are word aligned, the byte offset carries nothing.
    assign unused_addr_bits = ^bus.if_addr[1:0];

    // Tag/data storage has no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk_in) begin
        if (fill_done && !rst_in) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= bus.mc_out;
        end
    end

    // Lookup/fill controller with registered IF and memory-controller outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= IDLE;
            valid_bits  <= '0;
            fill_index  <= '0;
            fill_tag    <= '0;
            bus.if_rdy  <= 1'b0;
            bus.if_ins  <= 32'h0;
            bus.mc_op   <= 2'b00;
            bus.mc_len  <= 2'b00;
            bus.mc_addr <= 32'h0;
        end else if (rdy_in) begin
            bus.if_rdy <= 1'b0;

            if (fill_done) begin
                valid_bits[fill_index] <= 1'b1;
            end

            if (bus.flush) begin
                state      <= IDLE;
                bus.mc_op  <= 2'b00;
                bus.mc_len <= 2'b00;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.if_req) begin
                            if (req_hit) begin
                                bus.if_rdy <= 1'b1;
                                bus.if_ins <= data_mem[req_index];
                            end else begin
                                fill_index  <= req_index;
                                fill_tag    <= req_tag;
                                bus.mc_op   <= 2'b01;
                                bus.mc_len  <= 2'b11;
                                bus.mc_addr <= {bus.if_addr[31:2], 2'b00};
                                state       <= FILL;
                            end
                        end
                    end
                    FILL: begin
                        if (bus.mc_rdy) begin
                            bus.if_rdy <= 1'b1;
                            bus.if_ins <= bus.mc_out;
                            bus.mc_op  <= 2'b00;
                            bus.mc_len <= 2'b00;
                            state      <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: an IF-stage driver issues fetches and
// pushes the expected instruction, a monitor pops on every delivered if_rdy,
// and a behavioural memory controller answers reads with a random latency.
module tb_icache_direct;
    localparam int INDEX_BITS = 6;
    localparam int ADDR_BITS  = 18;
    localparam int LINES      = 1 << INDEX_BITS;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic rdy_q;

    icache_direct_if bus ();

    icache_direct #(
        .INDEX_BITS(INDEX_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    // Remembers whether the last rising edge was a live (unfrozen) one.
    always @(posedge clk_in) rdy_q <= rdy_in;

    int          checks      = 0;
    int          fails       = 0;
    int          deliveries  = 0;
    int          mc_reads    = 0;
    int          last_lat    = 0;
    int          force_lat   = 0;
    int          stall_left  = 0;
    int          stall_wait  = -1;
    bit          stall_en    = 1'b0;
    logic [31:0] drv_addr    = 32'h0;
    logic [31:0] exp_q[$];

    // Reference cache contents: which word address each line currently holds.
    bit          ref_valid [LINES];
    int          ref_tag   [LINES];

    // Immutable instruction memory; content depends only on the physical bits.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = (a % (32'h1 << ADDR_BITS)) / 4;
        return (w * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    function automatic int ref_index(input logic [31:0] a);
        return int'((a / 4) % LINES);
    endfunction

    function automatic int ref_tag_of(input logic [31:0] a);
        return int'((a % (32'h1 << ADDR_BITS)) / (4 * LINES));
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[ref_index(a)] && (ref_tag[ref_index(a)] == ref_tag_of(a));
    endfunction

    function automatic void ref_fill(input logic [31:0] a);
        ref_valid[ref_index(a)] = 1'b1;
        ref_tag[ref_index(a)]   = ref_tag_of(a);
    endfunction

    task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: scores each delivered instruction and checks freezing during stalls.
    logic [68:0] snap;
    bit          snap_ok = 1'b0;
    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                snap_ok = 1'b0;
                continue;
            end
            if (rdy_q) begin
                if (bus.if_rdy) begin
                    deliveries++;
                    if (exp_q.size() == 0)
                        check_output("if_rdy_unexpected", 96'(bus.if_rdy), 96'(0));
                    else
                        check_output("if_ins", 96'(bus.if_ins), 96'(exp_q.pop_front()));
                end
            end else if (snap_ok) begin
                check_output("frozen_outputs",
                             96'({bus.if_rdy, bus.if_ins, bus.mc_op, bus.mc_len, bus.mc_addr}),
                             96'(snap));
            end
            snap    = {bus.if_rdy, bus.if_ins, bus.mc_op, bus.mc_len, bus.mc_addr};
            snap_ok = 1'b1;
        end
    end

    // Memory controller model: one read at a time, aborts when mc_op drops.
    initial begin
        int          cnt;
        bit          busy;
        logic [31:0] cur_addr;
        cnt        = 0;
        busy       = 1'b0;
        cur_addr   = 32'h0;
        bus.mc_rdy = 1'b0;
        bus.mc_out = 32'h0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                bus.mc_rdy = 1'b0;
                busy       = 1'b0;
                continue;
            end
            if (!rdy_q) continue;
            if (bus.mc_rdy) begin
                bus.mc_rdy = 1'b0;
                busy       = 1'b0;
            end else if (busy) begin
                if (bus.mc_op == 2'b00) begin
                    busy = 1'b0;
                end else begin
                    check_output("mc_addr_held", 96'(bus.mc_addr), 96'(cur_addr));
                    check_output("mc_len_held", 96'(bus.mc_len), 96'(2'b11));
                    cnt--;
                    if (cnt == 0) begin
                        bus.mc_rdy = 1'b1;
                        bus.mc_out = mem_word(cur_addr);
                    end
                end
            end else if (bus.mc_op == 2'b01) begin
                mc_reads++;
                cur_addr = {drv_addr[31:2], 2'b00};
                check_output("mc_addr", 96'(bus.mc_addr), 96'(cur_addr));
                check_output("mc_len", 96'(bus.mc_len), 96'(2'b11));
                busy     = 1'b1;
                cnt      = (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
                last_lat = cnt;
            end
        end
    end

    // Advance to just after the falling edge and choose rdy_in for the next edge.
    task automatic sync_cycle();
        @(negedge clk_in);
        #1;
        if (stall_left > 0) begin
            rdy_in = 1'b0;
            stall_left--;
        end else begin
            rdy_in = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic do_reset();
        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        bus.flush   = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        repeat (2) @(negedge clk_in);
        #1;
        check_output("reset_if_rdy", 96'(bus.if_rdy), 96'(0));
        check_output("reset_if_ins", 96'(bus.if_ins), 96'(0));
        check_output("reset_mc_op", 96'(bus.mc_op), 96'(0));
        check_output("reset_mc_len", 96'(bus.mc_len), 96'(0));
        check_output("reset_mc_addr", 96'(bus.mc_addr), 96'(0));
        for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
        rst_in = 1'b0;
    endtask

    // mode 0: normal fetch; mode 1: flush k live cycles after the request
    // (k=0 means together with it); mode 2: flush in the cycle mc_rdy arrives.
    task automatic apply_stimulus(input logic [31:0] addr, input int mode, input int k);
        bit hit;
        bit done;
        bit flushed;
        int reads0;
        int deliv0;
        int waits;
        int kk;
        hit     = ref_hit(addr);
        reads0  = mc_reads;
        deliv0  = deliveries;
        kk      = k;
        done    = 1'b0;
        flushed = 1'b0;
        waits   = 0;
        drv_addr = addr;
        if (mode == 0) exp_q.push_back(mem_word(addr));
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        if (mode == 1 && kk == 0) begin
            rdy_in    = 1'b1;
            bus.flush = 1'b1;
            flushed   = 1'b1;
        end
        for (int guard = 0; guard < 400 && !done; guard++) begin
            sync_cycle();
            if (rdy_q) waits++;
            if (waits == stall_wait && stall_left == 0 && rdy_q) begin
                rdy_in     = 1'b0;
                stall_left = 2;
                stall_wait = -1;
            end
            if (flushed) begin
                if (rdy_q) begin
                    bus.flush  = 1'b0;
                    bus.if_req = 1'b0;
                    check_output("flush_if_rdy", 96'(bus.if_rdy), 96'(0));
                    check_output("flush_mc_op", 96'(bus.mc_op), 96'(0));
                    check_output("flush_reads", 96'(mc_reads - reads0),
                                 96'((mode == 1 && (kk == 0 || hit)) ? 0 : 1));
                    check_output("flush_no_delivery", 96'(deliveries - deliv0), 96'(0));
                    if (mode == 2) ref_fill(addr);
                    done = 1'b1;
                end
            end else if (mode == 0) begin
                if (deliveries != deliv0) begin
                    check_output(hit ? "hit_latency" : "miss_latency", 96'(waits),
                                 96'(hit ? 1 : last_lat + 2));
                    check_output(hit ? "hit_reads" : "miss_reads", 96'(mc_reads - reads0),
                                 96'(hit ? 0 : 1));
                    if (!hit) ref_fill(addr);
                    bus.if_req = 1'b0;
                    done       = 1'b1;
                end
            end else if (mode == 1) begin
                if (waits >= 1 && kk > last_lat) kk = last_lat;
                if (rdy_q && waits == kk) begin
                    rdy_in    = 1'b1;
                    bus.flush = 1'b1;
                    flushed   = 1'b1;
                end
            end else begin
                if (bus.mc_rdy) begin
                    rdy_in    = 1'b1;
                    bus.flush = 1'b1;
                    flushed   = 1'b1;
                end
            end
        end
        check_output("fetch_completed", 96'(done), 96'(1));
        bus.flush  = 1'b0;
        bus.if_req = 1'b0;
    endtask

    // Start a miss, then pull reset while the read is outstanding.
    task automatic reset_mid_fill(input logic [31:0] addr);
        drv_addr    = addr;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        for (int guard = 0; guard < 50 && bus.mc_op != 2'b01; guard++) sync_cycle();
        sync_cycle();
        do_reset();
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        bus.flush   = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = 32'h0;
        do_reset();

        // Cold miss, then a hit on the same word.
        force_lat = 4;
        apply_stimulus(32'h0000_0000, 0, 0);
        apply_stimulus(32'h0000_0000, 0, 0);

        // Conflicting tags on index 0 evict each other.
        apply_stimulus(32'h0000_0100, 0, 0);
        apply_stimulus(32'h0000_0000, 0, 0);

        // Flush two cycles into the fill, then an unrelated fetch.
        apply_stimulus(32'h0000_0040, 1, 3);
        apply_stimulus(32'h0000_0080, 0, 0);

        // Flush together with the returning read; the line still gets written.
        apply_stimulus(32'h0000_0044, 2, 0);
        apply_stimulus(32'h0000_0044, 0, 0);

        // Flush together with a hit, then a plain hit.
        apply_stimulus(32'h0000_0080, 1, 0);
        apply_stimulus(32'h0000_0080, 0, 0);

        // Reset in the middle of a fill leaves nothing behind.
        reset_mid_fill(32'h0000_0200);
        apply_stimulus(32'h0000_0200, 0, 0);
        apply_stimulus(32'h0000_0000, 0, 0);

        // Address bits above the physical range alias onto the same line.
        apply_stimulus(32'h0004_0200, 0, 0);
        apply_stimulus(32'hF000_0200, 0, 0);

        // Three-cycle freezes during a fill and during a hit.
        stall_wait = 2;
        apply_stimulus(32'h0000_0300, 0, 0);
        stall_wait = 1;
        apply_stimulus(32'h0000_0300, 0, 0);
        stall_wait = -1;

        // Random traffic over a small address pool with random stalls.
        force_lat = 0;
        stall_en  = 1'b1;
        for (int n = 0; n < 150; n++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 28);
            sel = int'($urandom_range(0, 9));
            if (sel == 7)
                apply_stimulus(a, 1, 0);
            else if (sel == 8 && !ref_hit(a))
                apply_stimulus(a, 1, int'($urandom_range(1, 3)));
            else if (sel == 9 && !ref_hit(a))
                apply_stimulus(a, 2, 0);
            else
                apply_stimulus(a, 0, 0);
        end

        stall_en = 1'b0;
        repeat (4) sync_cycle();
        check_output("scoreboard_drained", 96'(exp_q.size()), 96'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
